bias_spi_responder: RTL and testbench
=====================================

BIAS_SPI_RESPONDER -- requirements
Module: bias_spi_responder

Interface
REQ-001 SHALL have parameter MIN_BITS, default 8: minimum SCK rising edges with CS low for a frame to be accepted.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sck, input, 1: serial clock from the master, asynchronous to clk.
REQ-005 SHALL have port sdi, input, 1: serial data from the master, valid around sck rising edge.
REQ-006 SHALL have port cs, input, 1: bias chip select; low idle and while shifting, high to latch.
REQ-007 SHALL have port sdo, output, 1: serial status data to the master; changes after sck rising edge.
REQ-008 SHALL have port status_in, input, 6: switch status bits to report back.
REQ-009 SHALL have port ctl_out, output, 8: last accepted control byte {cfg[1:0], switch[5:0]}.
REQ-010 SHALL have port ctl_strobe, output, 1: one-cycle pulse when ctl_out updates.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse when a short frame is rejected.

Function
REQ-012 SHALL pass sck, sdi and cs each through a 2-flop synchronizer, plus one history flop on sck and cs, for edge detection.
REQ-013 SHALL detect an sck rise when the synced sck is 1 and its history is 0, and likewise for a cs rise.
REQ-014 SHALL apply actions on the clk edge at which the rise is detected: pin change to register update is 3 clk cycles, given setup is met.
REQ-015 SHALL, on an sck rise with synced cs low, shift the synced sdi into rx_sr[0] (MSB first), giving rx_sr <= {rx_sr[6:0], sdi}.
REQ-016 SHALL, on the same sck rise with cs low, shift tx_sr left with 0 fill, and increment bit_cnt (4 bits), saturating at 15.
REQ-017 SHALL, on a cs rise with bit_cnt >= MIN_BITS, load ctl_out <= rx_sr and pulse ctl_strobe for exactly 1 cycle.
REQ-018 SHALL, on a cs rise with bit_cnt < MIN_BITS, leave ctl_out unchanged and pulse frame_err for 1 cycle.
REQ-019 SHALL clear bit_cnt to 0 on every cs rise.
REQ-020 SHALL, with more than 8 bits in a frame, accept the last 8 bits shifted.
REQ-021 SHALL, on an sck rise with synced cs high, load tx_sr <= {status_in, 2'b00}; repeated rises while cs is high reload the register.
REQ-022 SHALL drive sdo = tx_sr[7] as a registered output; the status MSB appears after the load, and each later cs-low sck rise advances 1 bit.
REQ-023 SHALL leave sdo at 0 after 6 status bits have shifted out, until the next load.
REQ-024 SHALL make the sck action use the synced cs value present at detection.
REQ-025 SHALL handle a cs rise and sck rise detected on the same cycle as follows: latch/reject uses rx_sr and bit_cnt before this edge, and the sck rise acts as a status load.
REQ-026 SHALL handle a cs fall and sck rise on the same cycle as a shift (cs low).
REQ-027 SHALL ignore sdi while cs is high, and SHALL take no action on a cs fall.
REQ-028 SHALL define state as two phases, set by the synced cs level: SHIFT (cs low) and LATCH (cs high).
REQ-029 SHALL never let ctl_strobe and frame_err assert in the same cycle.

Reset
REQ-030 SHALL, while rst_n is low, force the following to 0 immediately and asynchronously: sdo, ctl_out, ctl_strobe, frame_err, rx_sr, tx_sr, bit_cnt, all synchronizer and history flops.
REQ-031 SHALL, if rst_n is asserted mid-frame, discard the partial frame; after release, a cs rise with fewer than MIN_BITS new bits gives frame_err, not a stale update.
REQ-032 SHALL treat synchronizer flops reset to 0 as producing no spurious edge at reset release when the pins are low.

Verification
REQ-033 Good frame: cs low, 8 sck pulses (each high and low for >= 4 clk) sending 0xA5 MSB first, then cs raised -> ctl_out=0xA5 and one ctl_strobe pulse, 3 clk after the cs pin rise.
REQ-034 Short frame: 5 bits sent, then cs raised -> ctl_out keeps its prior value (0xA5), one frame_err pulse, no ctl_strobe.
REQ-035 Readback: status_in=6'b101101, one sck pulse with cs high, then cs low and 6 sck pulses -> sdo sequence 1,0,1,1,0,1, then 0 thereafter.
REQ-036 Long frame: 12 bits 0xF3C sent, then cs raised -> ctl_out=0x3C, ctl_strobe pulses, bit_cnt is 0 after the edge.
REQ-037 Coincident edges: cs and sck rise on the same clk edge after a valid 8-bit frame -> ctl_out is updated from the prior 8 bits and tx_sr is loaded with status_in.
REQ-038 Reset mid-frame: rst_n pulsed low after 4 bits -> all outputs are 0 immediately; after release, 4 more bits then cs rise -> frame_err pulses and ctl_out stays 0x00.

Source files
------------

// File: rtl/bias_spi_responder.sv
// Bias-control SPI responder: control bytes shift in while cs is low and are latched on the cs
// rising edge; switch status is loaded on an sck rise with cs high and shifted back out on sdo.
module bias_spi_responder #(
    parameter int MIN_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs,
    input  logic [5:0] status_in,
    output logic       sdo,
    output logic [7:0] ctl_out,
    output logic       ctl_strobe,
    output logic       frame_err,
    output logic       o_dbg_phase,
    output logic [3:0] o_dbg_bit_cnt
);

    // Phase follows the synchronized cs level; this register is the second cs sync stage.
    typedef enum logic {
        PH_SHIFT = 1'b0,
        PH_LATCH = 1'b1
    } phase_t;

    logic       r_sck_s1;
    logic       r_sck_s2;
    logic       r_sck_h;
    logic       r_sdi_s1;
    logic       r_sdi_s2;
    logic       r_cs_s1;
    phase_t     r_phase;
    logic       r_cs_h;
    logic [7:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_ctl_out;
    logic       r_ctl_strobe;
    logic       r_frame_err;

    logic       w_sck_rise;
    logic       w_cs_rise;
    logic       w_frame_ok;

    assign w_sck_rise = r_sck_s2 & ~r_sck_h;
    assign w_cs_rise  = (r_phase == PH_LATCH) & ~r_cs_h;
    assign w_frame_ok = int'(r_bit_cnt) >= MIN_BITS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_s1     <= 1'b0;
            r_sck_s2     <= 1'b0;
            r_sck_h      <= 1'b0;
            r_sdi_s1     <= 1'b0;
            r_sdi_s2     <= 1'b0;
            r_cs_s1      <= 1'b0;
            r_phase      <= PH_SHIFT;
            r_cs_h       <= 1'b0;
            r_rx_sr      <= 8'h00;
            r_tx_sr      <= 8'h00;
            r_bit_cnt    <= 4'd0;
            r_ctl_out    <= 8'h00;
            r_ctl_strobe <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sck_s1     <= sck;
            r_sck_s2     <= r_sck_s1;
            r_sck_h      <= r_sck_s2;
            r_sdi_s1     <= sdi;
            r_sdi_s2     <= r_sdi_s1;
            r_cs_s1      <= cs;
            r_phase      <= r_cs_s1 ? PH_LATCH : PH_SHIFT;
            r_cs_h       <= (r_phase == PH_LATCH);
            r_ctl_strobe <= 1'b0;
            r_frame_err  <= 1'b0;

            // The sck action looks at the cs level seen at detection, so a coincident
            // cs rise turns this sck rise into a status load.
            if (w_sck_rise) begin
                if (r_phase == PH_SHIFT) begin
                    r_rx_sr <= {r_rx_sr[6:0], r_sdi_s2};
                    r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                    if (r_bit_cnt != 4'd15) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end else begin
                    r_tx_sr <= {status_in, 2'b00};
                end
            end

            // A cs rise means phase is LATCH, so it never overlaps the shift branch above.
            if (w_cs_rise) begin
                r_bit_cnt <= 4'd0;
                if (w_frame_ok) begin
                    r_ctl_out    <= r_rx_sr;
                    r_ctl_strobe <= 1'b1;
                end else begin
                    r_frame_err  <= 1'b1;
                end
            end
        end
    end

    assign sdo           = r_tx_sr[7];
    assign ctl_out       = r_ctl_out;
    assign ctl_strobe    = r_ctl_strobe;
    assign frame_err     = r_frame_err;
    assign o_dbg_phase   = r_phase;
    assign o_dbg_bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_bias_spi_responder.sv
// Directed bench for bias_spi_responder: frames, readback, coincident edges and reset.
module tb_bias_spi_responder;

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       sdi;
  logic       cs;
  logic [5:0] status_in;
  logic       sdo;
  logic [7:0] ctl_out;
  logic       ctl_strobe;
  logic       frame_err;
  logic       dbg_phase;
  logic [3:0] dbg_bit_cnt;

  int n_pass;
  int n_total;

  int w_strobe;
  int w_err;
  int w_first_strobe;
  int w_first_err;
  int w_both;
  int quiet_pulses;

  bias_spi_responder #(.MIN_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sck           (sck),
    .sdi           (sdi),
    .cs            (cs),
    .status_in     (status_in),
    .sdo           (sdo),
    .ctl_out       (ctl_out),
    .ctl_strobe    (ctl_strobe),
    .frame_err     (frame_err),
    .o_dbg_phase   (dbg_phase),
    .o_dbg_bit_cnt (dbg_bit_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one sck pulse; optionally check sdo just before the rising edge
  task automatic send_bit(input logic b, input logic chk, input logic exp_sdo, input string tag);
    @(negedge clk);
    sdi = b;
    wait_clk(2);
    if (chk) check(tag, int'(sdo), int'(exp_sdo));
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_word(input logic [16:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], 1'b0, 1'b0, "");
  endtask

  // raise cs (optionally with sck) and observe the pulse outputs for 10 cycles
  task automatic raise_cs(input logic with_sck);
    @(negedge clk);
    cs = 1'b1;
    if (with_sck) sck = 1'b1;
    w_strobe = 0; w_err = 0; w_first_strobe = 0; w_first_err = 0; w_both = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ctl_strobe) begin
        w_strobe++;
        if (w_first_strobe == 0) w_first_strobe = i;
      end
      if (frame_err) begin
        w_err++;
        if (w_first_err == 0) w_first_err = i;
      end
      if (ctl_strobe && frame_err) w_both++;
    end
  endtask

  task automatic lower_cs();
    @(negedge clk);
    cs = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    sck = 1'b0;
    sdi = 1'b0;
    cs = 1'b0;
    status_in = 6'b000000;
    wait_clk(3);
    check("rst_sdo", int'(sdo), 0);
    check("rst_ctl_out", int'(ctl_out), 'h00);
    check("rst_strobe", int'(ctl_strobe), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_phase", int'(dbg_phase), 0);
    check("rst_bit_cnt", int'(dbg_bit_cnt), 0);

    // release with pins low: no spurious edges
    rst_n = 1'b1;
    quiet_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ctl_strobe || frame_err) quiet_pulses++;
    end
    check("release_quiet", quiet_pulses, 0);

    // good frame 0xA5
    send_word(17'h000A5, 8);
    check("good_bit_cnt", int'(dbg_bit_cnt), 8);
    raise_cs(1'b0);
    check("good_strobe_cnt", w_strobe, 1);
    check("good_strobe_lat", w_first_strobe, 3);
    check("good_err_cnt", w_err, 0);
    check("good_ctl_out", int'(ctl_out), 'hA5);
    check("good_bit_cnt_clr", int'(dbg_bit_cnt), 0);
    check("good_phase_latch", int'(dbg_phase), 1);

    // short frame: 5 bits
    lower_cs();
    send_word(17'h00013, 5);
    raise_cs(1'b0);
    check("short_err_cnt", w_err, 1);
    check("short_err_lat", w_first_err, 3);
    check("short_strobe_cnt", w_strobe, 0);
    check("short_ctl_out", int'(ctl_out), 'hA5);

    // readback of status 101101, then one extra bit (7-bit frame rejected)
    status_in = 6'b101101;
    send_bit(1'b1, 1'b0, 1'b0, "");
    check("rb_load_sdo", int'(sdo), 1);
    check("rb_load_no_cnt", int'(dbg_bit_cnt), 0);
    lower_cs();
    send_bit(1'b0, 1'b1, 1'b1, "rb_sdo0");
    send_bit(1'b0, 1'b1, 1'b0, "rb_sdo1");
    send_bit(1'b0, 1'b1, 1'b1, "rb_sdo2");
    send_bit(1'b0, 1'b1, 1'b1, "rb_sdo3");
    send_bit(1'b0, 1'b1, 1'b0, "rb_sdo4");
    send_bit(1'b0, 1'b1, 1'b1, "rb_sdo5");
    send_bit(1'b0, 1'b1, 1'b0, "rb_sdo6");
    check("rb_sdo_after", int'(sdo), 0);
    check("rb_bit_cnt7", int'(dbg_bit_cnt), 7);
    raise_cs(1'b0);
    check("min_minus1_err", w_err, 1);
    check("min_minus1_strobe", w_strobe, 0);
    check("min_minus1_ctl", int'(ctl_out), 'hA5);

    // long frame: 12 bits 0xF3C keeps the last 8
    lower_cs();
    send_word(17'h00F3C, 12);
    check("long_bit_cnt", int'(dbg_bit_cnt), 12);
    raise_cs(1'b0);
    check("long_strobe_cnt", w_strobe, 1);
    check("long_ctl_out", int'(ctl_out), 'h3C);
    check("long_bit_cnt_clr", int'(dbg_bit_cnt), 0);

    // 17 bits: counter saturates at 15
    lower_cs();
    send_word(17'h15A96, 17);
    check("sat_bit_cnt", int'(dbg_bit_cnt), 15);
    raise_cs(1'b0);
    check("sat_strobe_cnt", w_strobe, 1);
    check("sat_ctl_out", int'(ctl_out), 'h96);

    // coincident cs and sck rise after a valid frame
    lower_cs();
    status_in = 6'b100110;
    send_word(17'h0005A, 8);
    check("coin_sdo_before", int'(sdo), 0);
    raise_cs(1'b1);
    check("coin_strobe_cnt", w_strobe, 1);
    check("coin_err_cnt", w_err, 0);
    check("coin_ctl_out", int'(ctl_out), 'h5A);
    check("coin_sdo_loaded", int'(sdo), 1);
    check("coin_bit_cnt", int'(dbg_bit_cnt), 0);
    @(negedge clk);
    sck = 1'b0;
    wait_clk(4);
    lower_cs();
    check("cs_fall_no_pulse", int'(ctl_strobe | frame_err), 0);

    // mid-frame reset: 4 bits shifted while status drains out
    send_bit(1'b1, 1'b0, 1'b0, "");
    check("drain_sdo1", int'(sdo), 0);
    send_bit(1'b1, 1'b0, 1'b0, "");
    check("drain_sdo2", int'(sdo), 0);
    send_bit(1'b1, 1'b0, 1'b0, "");
    check("drain_sdo3", int'(sdo), 1);
    send_bit(1'b1, 1'b0, 1'b0, "");
    check("drain_sdo4", int'(sdo), 1);
    check("pre_rst_bit_cnt", int'(dbg_bit_cnt), 4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sdo", int'(sdo), 0);
    check("async_rst_ctl_out", int'(ctl_out), 'h00);
    check("async_rst_bit_cnt", int'(dbg_bit_cnt), 0);
    check("async_rst_pulses", int'(ctl_strobe | frame_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(4);
    send_word(17'h0000F, 4);
    raise_cs(1'b0);
    check("post_rst_err_cnt", w_err, 1);
    check("post_rst_strobe_cnt", w_strobe, 0);
    check("post_rst_ctl_out", int'(ctl_out), 'h00);

    check("never_both", w_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
